// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU operation sequencer: opcode encodings, FSM states
// and small opcode classification helpers.
package alu_seq_pkg;

    localparam logic [2:0] OP_F0        = 3'd0;
    localparam logic [2:0] OP_F1        = 3'd1;
    localparam logic [2:0] OP_F2        = 3'd2;
    localparam logic [2:0] OP_F3        = 3'd3;
    localparam logic [2:0] OP_F4        = 3'd4;
    localparam logic [2:0] OP_MAX_LEGAL = OP_F4;

    // Prefixed names keep the states distinct from the SETTLE timing parameter.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_MAX_LEGAL);
    endfunction

    // Only the arithmetic results (f0..f2) carry a meaningful overflow bit.
    function automatic logic op_has_ovf(input logic [2:0] op);
        return (op <= OP_F2);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request strictly after
// the pointer (wrapping) wins; returns a one-hot grant and its index.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);

    localparam int IW = $clog2(NREQ);

    int w_cand;

    always_comb begin
        gnt    = '0;
        idx    = '0;
        any    = 1'b0;
        w_cand = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = (int'(ptr) + k) % NREQ;
            if (!any && req[w_cand]) begin
                any         = 1'b1;
                gnt[w_cand] = 1'b1;
                idx         = IW'(w_cand);
            end
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Time-shares one combinational ALU among NREQ requesters with round-robin grant.
// Optional STICKY_OVF_EN adds ovf_sticky/ovf_clr: a latched overflow indicator.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NREQ   = 2,
    parameter int SETTLE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [3*NREQ-1:0]       req_op,
    input  logic [WIDTH*NREQ-1:0]   req_a,
    input  logic [WIDTH*NREQ-1:0]   req_b,
    output logic [WIDTH-1:0]        alu_a,
    output logic [WIDTH-1:0]        alu_b,
    output logic [2:0]              alu_s,
    input  logic [WIDTH-1:0]        alu_f,
    input  logic                    alu_ovf,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]        rsp_f,
    output logic                    rsp_ovf,
    output logic                    rsp_err
`ifdef STICKY_OVF_EN
    ,
    output logic                    ovf_sticky,
    input  logic                    ovf_clr
`endif
);

    localparam int IW = $clog2(NREQ);

    state_e            r_state;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_id;
    logic [3:0]        r_cnt;
    logic [2:0]        r_op;

    logic [NREQ-1:0]   w_gnt;
    logic [IW-1:0]     w_idx;
    logic              w_any;
    int                w_sel;
    logic [2:0]        w_op;
    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_b;
    logic              w_legal_cap;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req (req_valid),
        .ptr (r_ptr),
        .gnt (w_gnt),
        .idx (w_idx),
        .any (w_any)
    );

    assign w_sel       = int'(w_idx);
    assign w_op        = req_op[3*w_sel +: 3];
    assign w_a         = req_a[WIDTH*w_sel +: WIDTH];
    assign w_b         = req_b[WIDTH*w_sel +: WIDTH];
    assign w_legal_cap = op_is_legal(r_op);

    // The accept strobe exists only while idle; a response handshake never overlaps a grant.
    assign req_ready = (r_state == ST_IDLE) ? w_gnt : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= IW'(NREQ - 1);
            r_id      <= '0;
            r_cnt     <= '0;
            r_op      <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_f     <= '0;
            rsp_ovf   <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        alu_a   <= w_a;
                        alu_b   <= w_b;
                        alu_s   <= op_is_legal(w_op) ? w_op : OP_F0;
                        r_op    <= w_op;
                        r_id    <= w_idx;
                        r_ptr   <= w_idx;
                        r_cnt   <= 4'(SETTLE - 1);
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= r_id;
                        rsp_f     <= w_legal_cap ? alu_f : '0;
                        rsp_ovf   <= op_has_ovf(r_op) && alu_ovf;
                        rsp_err   <= !w_legal_cap;
                        r_state   <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef STICKY_OVF_EN
    // A setting handshake takes priority over a coincident clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (rsp_valid && rsp_ready && rsp_ovf) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios plus random traffic
// against a transaction-level reference model; define STICKY_OVF_EN for the sticky test.
module tb_alu_op_sequencer;

    localparam int WIDTH  = 16;
    localparam int NREQ   = 3;
    localparam int SETTLE = 1;
    localparam int IW     = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [3*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic [WIDTH-1:0]      alu_a;
    logic [WIDTH-1:0]      alu_b;
    logic [2:0]            alu_s;
    logic [WIDTH-1:0]      alu_f;
    logic                  alu_ovf;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IW-1:0]         rsp_id;
    logic [WIDTH-1:0]      rsp_f;
    logic                  rsp_ovf;
    logic                  rsp_err;
    logic                  ovf_clr = 1'b0;
`ifdef STICKY_OVF_EN
    logic                  ovf_sticky;
`endif

    alu_op_sequencer #(
        .WIDTH  (WIDTH),
        .NREQ   (NREQ),
        .SETTLE (SETTLE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_s      (alu_s),
        .alu_f      (alu_f),
        .alu_ovf    (alu_ovf),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_f      (rsp_f),
        .rsp_ovf    (rsp_ovf),
        .rsp_err    (rsp_err)
`ifdef STICKY_OVF_EN
        ,
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural ALU: add/sub/inc with signed overflow, and/or with a junk overflow bit.
    function automatic logic [WIDTH:0] alu_fn(input logic [2:0] s, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] f;
        logic             o;
        case (s)
            3'd0: begin f = a + b; o = (a[WIDTH-1] == b[WIDTH-1]) && (f[WIDTH-1] != a[WIDTH-1]); end
            3'd1: begin f = a - b; o = (a[WIDTH-1] != b[WIDTH-1]) && (f[WIDTH-1] != a[WIDTH-1]); end
            3'd2: begin f = a + WIDTH'(1); o = (a == {1'b0, {(WIDTH-1){1'b1}}}); end
            3'd3: begin f = a & b; o = a[0] ^ b[0]; end
            3'd4: begin f = a | b; o = a[0] ^ b[0]; end
            default: begin f = a ^ b; o = 1'b1; end
        endcase
        return {o, f};
    endfunction

    assign {alu_ovf, alu_f} = alu_fn(alu_s, alu_a, alu_b);

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Requester-side command data.
    logic [2:0]       d_op [NREQ];
    logic [WIDTH-1:0] d_a  [NREQ];
    logic [WIDTH-1:0] d_b  [NREQ];

    // Reference model: transaction-level view of the sequencer.
    int               m_ptr;
    int               m_wait;
    bit               m_rsp;
    int               m_id;
    logic [WIDTH-1:0] m_f, m_a, m_b;
    logic [2:0]       m_s;
    logic             m_ovf, m_err, m_sticky;

    task automatic set_req(input int i, input logic [2:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b);
        d_op[i] = op;
        d_a[i]  = a;
        d_b[i]  = b;
    endtask

    task automatic model_reset();
        m_ptr = NREQ - 1; m_wait = 0; m_rsp = 0; m_id = 0;
        m_f = '0; m_a = '0; m_b = '0; m_s = '0; m_ovf = 0; m_err = 0; m_sticky = 0;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model.
    task automatic step(input logic [NREQ-1:0] v, input logic rr);
        int               g;
        int               c;
        logic [NREQ-1:0]  eg;
        logic [WIDTH:0]   e;
        bit               legal;
        bit               hs;
        for (int i = 0; i < NREQ; i++) begin
            req_op[3*i +: 3]         = d_op[i];
            req_a[WIDTH*i +: WIDTH]  = d_a[i];
            req_b[WIDTH*i +: WIDTH]  = d_b[i];
        end
        req_valid = v;
        rsp_ready = rr;
        #1;
        g = -1;
        if (!m_rsp && m_wait == 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                c = (m_ptr + k) % NREQ;
                if (g < 0 && v[c]) g = c;
            end
        end
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(eg));
        check("rsp_valid", 64'(rsp_valid), 64'(m_rsp));
        check("alu_a", 64'(alu_a), 64'(m_a));
        check("alu_b", 64'(alu_b), 64'(m_b));
        check("alu_s", 64'(alu_s), 64'(m_s));
        if (m_rsp) begin
            check("rsp_id", 64'(rsp_id), 64'(m_id));
            check("rsp_f", 64'(rsp_f), 64'(m_f));
            check("rsp_ovf", 64'(rsp_ovf), 64'(m_ovf));
            check("rsp_err", 64'(rsp_err), 64'(m_err));
        end
`ifdef STICKY_OVF_EN
        check("ovf_sticky", 64'(ovf_sticky), 64'(m_sticky));
`endif
        hs = m_rsp && rr;
        @(posedge clk);
        if (hs && m_ovf) m_sticky = 1'b1;
        else if (ovf_clr) m_sticky = 1'b0;
        if (hs) begin
            m_rsp = 0;
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) m_rsp = 1;
        end else if (g >= 0) begin
            legal  = (d_op[g] <= 3'd4);
            e      = alu_fn(d_op[g], d_a[g], d_b[g]);
            m_ptr  = g;
            m_id   = g;
            m_wait = SETTLE;
            m_a    = d_a[g];
            m_b    = d_b[g];
            m_s    = legal ? d_op[g] : 3'd0;
            m_f    = legal ? e[WIDTH-1:0] : '0;
            m_ovf  = (d_op[g] <= 3'd2) ? e[WIDTH] : 1'b0;
            m_err  = !legal;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_f", 64'(rsp_f), 64'(0));
        check("rst_rsp_id", 64'(rsp_id), 64'(0));
        check("rst_rsp_ovf_err", 64'({rsp_ovf, rsp_err}), 64'(0));
        check("rst_alu", 64'({alu_s, alu_a, alu_b}), 64'(0));
`ifdef STICKY_OVF_EN
        check("rst_sticky", 64'(ovf_sticky), 64'(0));
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, 3'd0, '0, '0);
        model_reset();
        @(negedge clk);
        do_reset();

        // Single add from requester 0.
        set_req(0, 3'd0, 16'd5, 16'd3);
        step(3'b001, 1'b1);
        step(3'b000, 1'b1);
        step(3'b000, 1'b1);
        step(3'b000, 1'b1);

        // Two requesters continuously valid alternate.
        set_req(0, 3'd1, 16'd100, 16'd30);
        set_req(1, 3'd4, 16'h0F0F, 16'h3000);
        for (int n = 0; n < 12; n++) step(3'b011, 1'b1);

        // Back-pressure in the response phase.
        set_req(1, 3'd2, 16'h7FFF, 16'd0);
        step(3'b010, 1'b0);
        for (int n = 0; n < 6; n++) step(3'b111, 1'b0);
        step(3'b111, 1'b1);
        step(3'b111, 1'b1);
        for (int n = 0; n < 4; n++) step(3'b000, 1'b1);

        // Illegal opcode, and an and-op whose raw ALU overflow is high.
        set_req(0, 3'd6, 16'h1234, 16'h4321);
        step(3'b001, 1'b1);
        for (int n = 0; n < 3; n++) step(3'b000, 1'b1);
        set_req(2, 3'd3, 16'd1, 16'd0);
        step(3'b100, 1'b1);
        for (int n = 0; n < 3; n++) step(3'b000, 1'b1);

        // Reset while settling abandons the operation; requester 0 wins first afterwards.
        set_req(1, 3'd0, 16'd9, 16'd9);
        step(3'b010, 1'b1);
        do_reset();
        set_req(0, 3'd0, 16'h8000, 16'h8000);
        step(3'b011, 1'b1);
        for (int n = 0; n < 4; n++) step(3'b000, 1'b1);

`ifdef STICKY_OVF_EN
        // Overflow sets the sticky bit; a clear coinciding with another overflow handshake loses.
        set_req(0, 3'd0, 16'h7FFF, 16'd1);
        step(3'b001, 1'b1);
        step(3'b000, 1'b0);
        step(3'b000, 1'b1);
        step(3'b000, 1'b1);
        step(3'b001, 1'b1);
        step(3'b000, 1'b0);
        ovf_clr = 1'b1;
        step(3'b000, 1'b1);
        ovf_clr = 1'b0;
        step(3'b000, 1'b1);
        ovf_clr = 1'b1;
        step(3'b000, 1'b1);
        ovf_clr = 1'b0;
        step(3'b000, 1'b1);
`endif

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            logic [NREQ-1:0] v;
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, 3'($urandom_range(0, 7)), WIDTH'($urandom), WIDTH'($urandom));
                if ($urandom_range(0, 3) == 0) d_a[i] = {1'b0, {(WIDTH-1){1'b1}}};
                v[i] = ($urandom_range(0, 2) != 0);
            end
            ovf_clr = ($urandom_range(0, 7) == 0);
            step(v, $urandom_range(0, 3) != 0);
        end
        ovf_clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
